// File: rtl/noc_arb_pkg.sv
// Shared definitions for the NoC output arbiter: port indices, output FSM
// states and the dimension-ordered (YX) route function.
package noc_arb_pkg;

   localparam int NPORTS = 5;

   localparam logic [2:0] PORT_N = 3'd0;
   localparam logic [2:0] PORT_S = 3'd1;
   localparam logic [2:0] PORT_W = 3'd2;
   localparam logic [2:0] PORT_E = 3'd3;
   localparam logic [2:0] PORT_L = 3'd4;

   // Widest coordinate the route function handles; narrower ones are zero-extended.
   localparam int MAX_COORD_W = 16;
   typedef logic [MAX_COORD_W-1:0] coord_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } out_state_t;

   // Resolve Y first, then X; a fully matching address ejects to the local port.
   function automatic logic [2:0] route_yx(input coord_t cur_x, input coord_t cur_y,
                                           input coord_t dst_x, input coord_t dst_y);
      if (dst_y > cur_y)      return PORT_N;
      else if (dst_y < cur_y) return PORT_S;
      else if (dst_x > cur_x) return PORT_E;
      else if (dst_x < cur_x) return PORT_W;
      else                    return PORT_L;
   endfunction

endpackage

// File: rtl/noc_rr_out.sv
// One output port's round-robin arbiter: IDLE/BUSY FSM, rotating pointer and,
// when NOC_ARB_GRANT_TIMEOUT_EN is defined, a hold counter forcing release.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no grant held; picks first requester at index >= ptr
// ST_BUSY | grant held and frozen until release (or hold timeout)
module noc_rr_out
   import noc_arb_pkg::*;
#(
   parameter int MAX_HOLD = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NPORTS-1:0] req,
   input  logic              rel_req,
   output logic [NPORTS-1:0] grant,
   output logic              timeout,
   output logic [NPORTS-1:0] clr
);

   out_state_t        state, state_nxt;
   logic [NPORTS-1:0] grant_nxt;
   logic [2:0]        ptr, ptr_nxt;
   logic [2:0]        win, win_nxt;
   logic [2:0]        pick_idx;
   logic              pick_found;
   logic              forced;
   logic              end_grant;

`ifdef NOC_ARB_GRANT_TIMEOUT_EN
   localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   logic [HOLD_W-1:0] hold;

   assign forced = (state == ST_BUSY) && (hold == HOLD_W'(MAX_HOLD - 1));

   // Count consecutive BUSY cycles; restart whenever the grant ends.
   always_ff @(posedge clk) begin
      if (reset)                              hold <= '0;
      else if (state == ST_BUSY && !end_grant) hold <= hold + 1'b1;
      else                                    hold <= '0;
   end

   // A release arriving together with the timeout wins, so no pulse then.
   always_ff @(posedge clk) begin
      if (reset) timeout <= 1'b0;
      else       timeout <= forced && !rel_req;
   end
`else
   assign forced  = 1'b0;
   assign timeout = 1'b0;
`endif

   assign end_grant = (state == ST_BUSY) && (rel_req || forced);
   // The winner's next-hop entry is retired on the same edge the grant drops.
   assign clr       = end_grant ? grant : '0;

   // Rotating search for the first requester starting at ptr.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int k = 0; k < NPORTS; k++) begin
         int j;
         j = (int'(ptr) + k) % NPORTS;
         if (!pick_found && req[j]) begin
            pick_found = 1'b1;
            pick_idx   = 3'(j);
         end
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      ptr_nxt   = ptr;
      win_nxt   = win;
      case (state)
         ST_IDLE: begin
            if (pick_found) begin
               state_nxt = ST_BUSY;
               grant_nxt = NPORTS'(1) << pick_idx;
               win_nxt   = pick_idx;
            end
         end
         ST_BUSY: begin
            if (end_grant) begin
               state_nxt = ST_IDLE;
               grant_nxt = '0;
               ptr_nxt   = (win == 3'(NPORTS - 1)) ? 3'd0 : win + 3'd1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State, grant, pointer and winner registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         grant <= '0;
         ptr   <= '0;
         win   <= '0;
      end else begin
         state <= state_nxt;
         grant <= grant_nxt;
         ptr   <= ptr_nxt;
         win   <= win_nxt;
      end
   end

endmodule

// File: rtl/noc_arbiter_param.sv
// Five-port NoC router arbiter: per-input YX next-hop registers feeding five
// independent round-robin output arbiters. Optional grant hold timeout is
// enabled with macro NOC_ARB_GRANT_TIMEOUT_EN.
module noc_arbiter_param
   import noc_arb_pkg::*;
#(
   parameter int COORD_W  = 4,
   parameter int MAX_HOLD = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [2*COORD_W-1:0]       router_addr_i,
   input  logic [NPORTS*2*COORD_W-1:0] hdr_addr_i,
   input  logic [NPORTS-1:0]          hdr_valid_i,
   input  logic [NPORTS-1:0]          release_i,
   output logic [NPORTS*NPORTS-1:0]   grant_o,
   output logic [NPORTS-1:0]          busy_o,
   output logic [NPORTS-1:0]          timeout_o
);

   localparam int AW = 2 * COORD_W;

   logic [NPORTS-1:0] nh_valid;
   logic [2:0]        nh_route  [NPORTS];
   logic [2:0]        hdr_route [NPORTS];
   logic [NPORTS-1:0] req_out   [NPORTS];
   logic [NPORTS-1:0] clr_out   [NPORTS];
   logic [NPORTS-1:0] clr_in;

   // Route each input's header; address layout is {X, Y}.
   always_comb begin
      for (int i = 0; i < NPORTS; i++) begin
         hdr_route[i] = route_yx(coord_t'(router_addr_i[AW-1:COORD_W]),
                                 coord_t'(router_addr_i[COORD_W-1:0]),
                                 coord_t'(hdr_addr_i[i*AW+COORD_W +: COORD_W]),
                                 coord_t'(hdr_addr_i[i*AW +: COORD_W]));
      end
   end

   // Fan next-hop entries out into per-output request vectors.
   always_comb begin
      for (int o = 0; o < NPORTS; o++) begin
         req_out[o] = '0;
         for (int i = 0; i < NPORTS; i++)
            req_out[o][i] = nh_valid[i] && (nh_route[i] == 3'(o));
      end
   end

   // Collect retire strobes from all outputs per input.
   always_comb begin
      clr_in = '0;
      for (int o = 0; o < NPORTS; o++)
         clr_in = clr_in | clr_out[o];
   end

   // Next-hop registers: load once per packet, hold until the winner is released.
   always_ff @(posedge clk) begin
      if (reset) begin
         nh_valid <= '0;
         for (int i = 0; i < NPORTS; i++) nh_route[i] <= '0;
      end else begin
         for (int i = 0; i < NPORTS; i++) begin
            if (clr_in[i]) begin
               nh_valid[i] <= 1'b0;
            end else if (hdr_valid_i[i] && !nh_valid[i]) begin
               nh_valid[i] <= 1'b1;
               nh_route[i] <= hdr_route[i];
            end
         end
      end
   end

   for (genvar o = 0; o < NPORTS; o++) begin : g_out
      noc_rr_out #(
         .MAX_HOLD (MAX_HOLD)
      ) u_out (
         .clk     (clk),
         .reset   (reset),
         .req     (req_out[o]),
         .rel_req (release_i[o]),
         .grant   (grant_o[o*NPORTS +: NPORTS]),
         .timeout (timeout_o[o]),
         .clr     (clr_out[o])
      );
      assign busy_o[o] = |grant_o[o*NPORTS +: NPORTS];
   end

endmodule

// File: tb/tb_noc_arbiter_param.sv
// Scoreboard bench for noc_arbiter_param: stimulus pushes expected output
// changes (cycle + values); a negedge monitor pops one per observed change.
module tb_noc_arbiter_param;

   localparam int COORD_W  = 4;
   localparam int MAX_HOLD = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  router_addr_i;
   logic [39:0] hdr_addr_i;
   logic [4:0]  hdr_valid_i;
   logic [4:0]  release_i;
   logic [24:0] grant_o;
   logic [4:0]  busy_o;
   logic [4:0]  timeout_o;

   noc_arbiter_param #(
      .COORD_W  (COORD_W),
      .MAX_HOLD (MAX_HOLD)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .router_addr_i (router_addr_i),
      .hdr_addr_i    (hdr_addr_i),
      .hdr_valid_i   (hdr_valid_i),
      .release_i     (release_i),
      .grant_o       (grant_o),
      .busy_o        (busy_o),
      .timeout_o     (timeout_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          id;
      int          cyc;
      logic [24:0] grant;
      logic [4:0]  busy;
      logic [4:0]  tmo;
   } exp_t;

   exp_t        sb_q[$];
   int          tests = 0;
   int          fails = 0;
   int          ev_id = 0;
   bit          mon_en = 1'b0;
   logic [34:0] prev, cur;
   exp_t        e;

   localparam logic [4:0] BUSY_E = 5'b01000;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick();
   endtask

   task automatic expect_at(input int c, input logic [24:0] g, input logic [4:0] b,
                            input logic [4:0] t);
      exp_t x;
      x.id = ev_id; x.cyc = c; x.grant = g; x.busy = b; x.tmo = t;
      ev_id++;
      sb_q.push_back(x);
   endtask

   task automatic set_hdr(input int port, input logic [7:0] addr);
      hdr_addr_i[port*8 +: 8] = addr;
      hdr_valid_i[port]       = 1'b1;
   endtask

   task automatic pulse_release(input logic [4:0] outs);
      release_i = outs;
      tick();
      release_i = '0;
   endtask

   // Monitor: every change of the output bundle must match the next expectation.
   always @(negedge clk) begin
      if (mon_en) begin
         cur = {grant_o, busy_o, timeout_o};
         if (cur !== prev) begin
            tests++;
            if (sb_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_change cyc=%0d: got grant=%h busy=%b tmo=%b, required no change",
                        cyc, grant_o, busy_o, timeout_o);
            end else begin
               e = sb_q.pop_front();
               if (e.cyc != cyc || grant_o !== e.grant || busy_o !== e.busy || timeout_o !== e.tmo) begin
                  fails++;
                  $display("FAIL ev%0d: got cyc=%0d grant=%h busy=%b tmo=%b, required cyc=%0d grant=%h busy=%b tmo=%b",
                           e.id, cyc, grant_o, busy_o, timeout_o, e.cyc, e.grant, e.busy, e.tmo);
               end
            end
            prev = cur;
         end
      end
   end

   int k, g, r;

   initial begin
      reset         = 1'b1;
      router_addr_i = 8'h22;
      hdr_addr_i    = '0;
      hdr_valid_i   = '0;
      release_i     = '0;
      repeat (3) tick();

      tests++; if (grant_o !== 25'd0) begin fails++; $display("FAIL reset_grant: got %h required 0", grant_o); end
      tests++; if (busy_o !== 5'd0)   begin fails++; $display("FAIL reset_busy: got %b required 0", busy_o); end
      tests++; if (timeout_o !== 5'd0) begin fails++; $display("FAIL reset_timeout: got %b required 0", timeout_o); end

      reset  = 1'b0;
      prev   = {grant_o, busy_o, timeout_o};
      mon_en = 1'b1;
      tick();

      // N, S, L all head east: served N, S, L with a bubble after each release.
      k = cyc;
      set_hdr(0, 8'h52); set_hdr(1, 8'h52); set_hdr(4, 8'h52);
      tick(); hdr_valid_i = '0;
      g = k + 2; expect_at(g, 25'(1) << 15, BUSY_E, 5'b0);
      wait_until(g + 1); r = cyc;
      expect_at(r + 1, '0, '0, '0); expect_at(r + 2, 25'(1) << 16, BUSY_E, 5'b0);
      pulse_release(5'b01000);
      g = r + 2; wait_until(g + 1); r = cyc;
      expect_at(r + 1, '0, '0, '0); expect_at(r + 2, 25'(1) << 19, BUSY_E, 5'b0);
      pulse_release(5'b01000);
      g = r + 2; wait_until(g + 1); r = cyc;
      expect_at(r + 1, '0, '0, '0);
      pulse_release(5'b01000);
      repeat (2) tick();

      // Single W header to east: two-cycle latency, release clears next cycle.
      k = cyc;
      set_hdr(2, 8'h52); tick(); hdr_valid_i = '0;
      g = k + 2; expect_at(g, 25'(1) << 17, BUSY_E, 5'b0);
      wait_until(g + 1); r = cyc;
      expect_at(r + 1, '0, '0, '0);
      pulse_release(5'b01000);
      repeat (2) tick();

      // Second W header while pending is dropped; a later one routes south.
      k = cyc;
      set_hdr(2, 8'h52); tick(); hdr_valid_i = '0;
      g = k + 2; expect_at(g, 25'(1) << 17, BUSY_E, 5'b0);
      wait_until(g);
      set_hdr(2, 8'h20); tick(); hdr_valid_i = '0;
      r = cyc; expect_at(r + 1, '0, '0, '0);
      pulse_release(5'b01000);
      tick();
      k = cyc;
      set_hdr(2, 8'h20); tick(); hdr_valid_i = '0;
      g = k + 2; expect_at(g, 25'(1) << 7, 5'b00010, 5'b0);
      wait_until(g + 1); r = cyc;
      expect_at(r + 1, '0, '0, '0);
      pulse_release(5'b00010);
      repeat (2) tick();

      // N and L contend for east; pointer sits at 3 so L goes first.
      k = cyc;
      set_hdr(0, 8'h52); set_hdr(4, 8'h52); tick(); hdr_valid_i = '0;
`ifdef NOC_ARB_GRANT_TIMEOUT_EN
      expect_at(k + 2, 25'(1) << 19, BUSY_E, 5'b0);
      expect_at(k + 6, '0, '0, 5'b01000);
      expect_at(k + 7, 25'(1) << 15, BUSY_E, 5'b0);
      expect_at(k + 11, '0, '0, '0);
      wait_until(k + 10);
      pulse_release(5'b01000);
`else
      expect_at(k + 2, 25'(1) << 19, BUSY_E, 5'b0);
      wait_until(k + 12); r = cyc;
      expect_at(r + 1, '0, '0, '0); expect_at(r + 2, 25'(1) << 15, BUSY_E, 5'b0);
      pulse_release(5'b01000);
      g = r + 2; wait_until(g + 1); r = cyc;
      expect_at(r + 1, '0, '0, '0);
      pulse_release(5'b01000);
`endif
      repeat (2) tick();

      // Reset mid-grant, then pointer back at N and two outputs granting together.
      k = cyc;
      set_hdr(2, 8'h52); tick(); hdr_valid_i = '0;
      g = k + 2; expect_at(g, 25'(1) << 17, BUSY_E, 5'b0);
      wait_until(g + 1);
      r = cyc; expect_at(r + 1, '0, '0, '0);
      reset = 1'b1; tick(); reset = 1'b0;
      k = cyc;
      set_hdr(0, 8'h52); set_hdr(4, 8'h52); set_hdr(3, 8'h22);
      tick(); hdr_valid_i = '0;
      g = k + 2; expect_at(g, (25'(1) << 15) | (25'(1) << 23), 5'b11000, 5'b0);
      wait_until(g + 1); r = cyc;
      expect_at(r + 1, '0, '0, '0); expect_at(r + 2, 25'(1) << 19, BUSY_E, 5'b0);
      pulse_release(5'b11000);
      g = r + 2; wait_until(g + 1); r = cyc;
      expect_at(r + 1, '0, '0, '0);
      pulse_release(5'b01000);

      for (int n = 0; n < 20 && sb_q.size() > 0; n++) tick();
      repeat (3) tick();
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         tests++; fails++;
         $display("FAIL ev%0d: got no output change, required cyc=%0d grant=%h busy=%b tmo=%b",
                  e.id, e.cyc, e.grant, e.busy, e.tmo);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/noc_arbiter_param.md
NOC_ARBITER_PARAM -- requirements
Module: noc_arbiter_param

Interface
REQ-001 SHALL provide parameter COORD_W, default 4, meaning the width of each X and Y coordinate; the address is {X,Y}, 2*COORD_W bits.
REQ-002 SHALL provide parameter MAX_HOLD, default 16, meaning the maximum number of grant cycles before a forced release (used only with the timeout feature).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 router_addr_i  input  2*COORD_W  this router's {X,Y} address.
REQ-007 hdr_addr_i  input  5*2*COORD_W  header destination per input port; slice i belongs to port i.
REQ-008 hdr_valid_i  input  5  per-input header strobe; writes that input's next-hop register.
REQ-009 release_i  input  5  per-output tail-passed strobe; ends the current grant on that output.
REQ-010 grant_o  output  25  slice [5o+4:5o] is a one-hot vector of the input granted to output o.
REQ-011 busy_o  output  5  per-output grant-active flag, for the crossbar.
REQ-012 timeout_o  output  5  per-output one-cycle forced-release pulse.

Function
REQ-013 Port indices SHALL be N=0, S=1, W=2, E=3, L=4, for both inputs and outputs.
REQ-014 Route SHALL be YX: Ydst>Ycur gives N; Ydst<Ycur gives S; otherwise Xdst>Xcur gives E, Xdst<Xcur gives W, and equal gives L. Comparisons are unsigned.
REQ-015 Per input: when hdr_valid_i[i] is high and nh_valid[i] is low, the computed route SHALL be registered and nh_valid[i] set at the next edge.
REQ-016 hdr_valid_i[i] SHALL be ignored while nh_valid[i] is set.
REQ-017 Input i SHALL request output o combinationally whenever nh_valid[i] is set and nh_route[i] equals o.
REQ-018 Each output SHALL run an FSM with states IDLE and BUSY.
REQ-019 In IDLE with at least one request, the output SHALL grant the first requester at index >= ptr, searching modulo 5, and enter BUSY; grant_o is registered.
REQ-020 Latency: a hdr_valid_i edge at cycle t SHALL give grant_o at t+2 when the output is uncontended.
REQ-021 In BUSY, release_i[o] SHALL cause the following transitions at the next edge:
- state returns to IDLE;
- grant slice clears;
- busy_o[o] clears;
- nh_valid of the winner clears;
- ptr becomes (winner+1) mod 5.
REQ-022 After a release, the output SHALL remain IDLE for one cycle (one-cycle bubble) before re-granting.
REQ-023 release_i[o] in IDLE SHALL be ignored.
REQ-024 A winner's request SHALL never re-arbitrate while BUSY; grant_o is stable for the whole of BUSY.
REQ-025 Different outputs SHALL arbitrate independently and may grant in the same cycle.
REQ-026 busy_o[o] SHALL equal the OR of grant slice o.

Reset
REQ-027 Reset SHALL drive the following values:
- grant_o, busy_o and timeout_o to 0;
- every FSM to IDLE;
- every ptr to 0 (N);
- every nh_valid to 0;
- every hold counter to 0.
REQ-028 Reset SHALL take priority over all other inputs and SHALL abort any active grant with no timeout_o pulse.

Configuration
REQ-029 With macro NOC_ARB_GRANT_TIMEOUT_EN defined, a per-output hold counter SHALL count BUSY cycles.
REQ-030 With the macro defined, reaching MAX_HOLD-1 without release SHALL force the release transitions of REQ-021 and pulse timeout_o[o] for one cycle.
REQ-031 With the macro defined, a release_i on the same cycle as the timeout SHALL be treated as a normal release with no pulse.
REQ-032 Without the macro, there SHALL be no counter, timeout_o SHALL be tied to 0, and grants SHALL hold indefinitely.

Structure
REQ-033 Package noc_arb_pkg SHALL hold the following:
- port index constants;
- NPORTS=5;
- the output FSM state enum;
- the YX route function.
REQ-034 Sub-module noc_rr_out SHALL implement one output's FSM, pointer and optional counter, instantiated 5 times.
REQ-035 The top level SHALL hold the route logic and the next-hop registers.

Verification (router_addr_i=0x22, COORD_W=4, MAX_HOLD=4)
REQ-036 Reset -> grant_o=0, busy_o=0, timeout_o=0, and the first arbitration favours N.
REQ-037 W header 0x52 at t -> grant_o[19:15]=00100 and busy_o[3]=1 at t+2; release_i[3] -> both clear on the next cycle.
REQ-038 N, S and L headers 0x52 together -> E grants N, then S, then L, with one idle cycle after each release.
REQ-039 Second W header 0x20 while W is pending -> ignored; after release, a new 0x20 header grants output S.
REQ-040 With the macro defined and no release -> timeout_o[3]=1 for one cycle after 4 BUSY cycles, grant clears, and the next requester is granted.
REQ-041 Reset asserted mid-BUSY -> all outputs 0 next cycle, no timeout pulse, and ptr=0.
